oam_dma_master: RTL and testbench

- Bus-initiator counterpart to the graphics OAM responder.
- The CPU writes a source page number XX to the DMA register, and the block copies 160 bytes from XX00–XX9F into OAM at FE00–FE9F.
- It sits between the CPU register port and the system data bus. It holds `busy` high so the CPU arbiter keeps the CPU off the bus during a copy.

---
 rtl/oam_dma_master.sv | 140 ++++++++++++++
 tb/tb_oam_dma_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_master.sv
// OAM DMA bus master. A CPU write of page XX to DMA_REG copies OAM_BYTES bytes from XX00 into OAM.
// Each byte takes READ -> CAPTURE -> WRITE, and every bus output is registered.
module oam_dma_master #(
    parameter int                   ADDR_SIZE = 16,
    parameter int                   DATA_SIZE = 8,
    parameter logic [ADDR_SIZE-1:0] DMA_REG   = 16'hFF46,
    parameter logic [ADDR_SIZE-1:0] OAM_LOC   = 16'hFE00,
    parameter int                   OAM_BYTES = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] reg_addr,
    input  logic [DATA_SIZE-1:0] reg_wdata,
    input  logic                 reg_we,
    output logic [DATA_SIZE-1:0] reg_rdata,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [DATA_SIZE-1:0] m_wdata,
    input  logic [DATA_SIZE-1:0] m_rdata,
    output logic                 m_re,
    output logic                 m_we,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    state_e                 state_q,   state_d;
    logic [DATA_SIZE-1:0]   page_q,    page_d;
    logic [7:0]             index_q,   index_d;
    logic [DATA_SIZE-1:0]   data_q,    data_d;
    logic [ADDR_SIZE-1:0]   m_addr_q,  m_addr_d;
    logic [DATA_SIZE-1:0]   m_wdata_q, m_wdata_d;
    logic                   m_re_q,    m_re_d;
    logic                   m_we_q,    m_we_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic                   start;

    // A page write starts a copy from any state, aborting whatever was in progress.
    assign start     = reg_we && (reg_addr == DMA_REG);
    assign reg_rdata = (reg_addr == DMA_REG) ? page_q : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        page_d    = page_q;
        index_d   = index_q;
        data_d    = data_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                data_d  = m_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A restart overrides the final-byte exit, so the aborted copy never raises done.
        if (start) begin
            page_d  = reg_wdata;
            index_d = 8'd0;
            state_d = S_READ;
            done_d  = 1'b0;
        end

        // Bus outputs are computed for the state being entered and registered with it.
        case (state_d)
            S_READ: begin
                m_re_d   = 1'b1;
                m_addr_d = ADDR_SIZE'({page_d, index_d});
            end
            S_WRITE: begin
                m_we_d    = 1'b1;
                m_addr_d  = OAM_LOC + ADDR_SIZE'(index_d);
                m_wdata_d = data_d;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            state_q   <= S_IDLE;
            page_q    <= '0;
            index_q   <= '0;
            data_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            index_q   <= index_d;
            data_q    <= data_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_re    = m_re_q;
    assign m_we    = m_we_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Bench for oam_dma_master: a memory responder, a bus monitor draining an expected-transfer
// scoreboard, and one task per scenario.
module tb_oam_dma_master;

    localparam logic [15:0] DMA_REG = 16'hFF46;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [15:0] reg_addr  = 16'h0000;
    logic [7:0]  reg_wdata = 8'h00;
    logic        reg_we    = 1'b0;
    logic [7:0]  reg_rdata;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata   = 8'h00;
    logic        m_re;
    logic        m_we;
    logic        busy;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;
    int mon_cyc      = 0;
    int done_cnt     = 0;
    int last_we_cyc  = 0;
    int strobe_cnt   = 0;

    logic [15:0] exp_rd[$];
    logic [23:0] exp_wr[$];

    oam_dma_master dut (
        .clk       (clk),
        .rst       (rst),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_re      (m_re),
        .m_we      (m_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Source memory: page C0 holds i^5A; other pages are also salted with the page number.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        logic [7:0] salt;
        salt = (a[15:8] == 8'hC0) ? 8'h00 : a[15:8];
        return a[7:0] ^ 8'h5A ^ salt;
    endfunction

    always @(posedge clk) begin
        if (m_re === 1'b1) m_rdata <= mem_fn(m_addr);
    end

    // Bus monitor: protocol rules plus scoreboard consumption, sampled on the falling edge.
    initial begin
        logic [15:0] e_rd;
        logic [23:0] e_wr;
        logic [15:0] addr_d1, addr_d2;
        logic        re_d1, re_d2, we_d1;
        addr_d1 = '0; addr_d2 = '0; re_d1 = 1'b0; re_d2 = 1'b0; we_d1 = 1'b0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (m_re === 1'b1 || m_we === 1'b1) strobe_cnt++;
            if (m_re === 1'b1 && m_we === 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL proto_re_we: both strobes high at cycle %0d", mon_cyc);
            end
            if (m_re === 1'b1) begin
                tests_run++;
                if (exp_rd.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_read: addr %h, none expected", m_addr);
                end else begin
                    e_rd = exp_rd.pop_front();
                    if (m_addr !== e_rd) begin
                        tests_failed++;
                        $display("FAIL read_addr: got %h expected %h", m_addr, e_rd);
                    end
                end
            end
            if (m_we === 1'b1) begin
                tests_run++;
                if (exp_wr.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", m_addr, m_wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if ({m_addr, m_wdata} !== e_wr) begin
                        tests_failed++;
                        $display("FAIL write: got %h/%h expected %h/%h",
                                 m_addr, m_wdata, e_wr[23:8], e_wr[7:0]);
                    end
                end
                tests_run++;
                if (re_d2 !== 1'b1 || m_wdata !== mem_fn(addr_d2)) begin
                    tests_failed++;
                    $display("FAIL write_vs_read2: wdata %h, re two cycles back %b addr %h expected data %h",
                             m_wdata, re_d2, addr_d2, mem_fn(addr_d2));
                end
                last_we_cyc = mon_cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                tests_run++;
                if (busy !== 1'b0 || we_d1 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL done_timing: busy %b, write in previous cycle %b (expected 0,1)",
                             busy, we_d1);
                end
            end
            addr_d2 = addr_d1; re_d2 = re_d1;
            addr_d1 = m_addr;  re_d1 = (m_re === 1'b1); we_d1 = (m_we === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_reg(input logic [15:0] addr, input logic [7:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic push_copy(input logic [7:0] page, input int n_rd, input int n_wr);
        for (int i = 0; i < n_rd; i++) exp_rd.push_back({page, 8'(i)});
        for (int i = 0; i < n_wr; i++)
            exp_wr.push_back({16'hFE00 + 16'(i), mem_fn({page, 8'(i)})});
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int s0;
        rst = 1'b1;
        tick();
        tick();
        reg_addr = DMA_REG;
        #1;
        tests_run++;
        if ({m_addr, m_wdata, m_re, m_we, busy, done} !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: addr %h wdata %h re %b we %b busy %b done %b, expected all 0",
                     m_addr, m_wdata, m_re, m_we, busy, done);
        end
        tests_run++;
        if (reg_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_page: got %h expected 00", reg_rdata);
        end
        rst = 1'b0;
        s0 = strobe_cnt;
        repeat (10) tick();
        tests_run++;
        if (strobe_cnt - s0 !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: %0d strobes busy %b, expected 0 strobes busy 0",
                     strobe_cnt - s0, busy);
        end
    endtask

    task automatic test_basic_copy();
        int d0, start, cyc;
        d0 = done_cnt;
        push_copy(8'hC0, 160, 160);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_before: got %b expected 0", busy);
        end
        drive_reg(DMA_REG, 8'hC0);
        start = mon_cyc;
        tests_run++;
        if (busy !== 1'b1 || m_re !== 1'b1 || m_addr !== 16'hC000) begin
            tests_failed++;
            $display("FAIL basic_first_read: busy %b re %b addr %h, expected 1 1 C000", busy, m_re, m_addr);
        end
        wait_done(600, cyc);
        tests_run++;
        if (done !== 1'b1 || cyc !== 480) begin
            tests_failed++;
            $display("FAIL basic_done_cycle: done %b after %0d cycles, expected 1 after 480", done, cyc);
        end
        tests_run++;
        if (last_we_cyc - start + 1 !== 480) begin
            tests_failed++;
            $display("FAIL basic_last_write_cycle: got %0d expected 480", last_we_cyc - start + 1);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_after: got %b expected 0", busy);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: done %b, %0d pulses, expected 0 and 1", done, done_cnt - d0);
        end
        tests_run++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL basic_drained: %0d reads %0d writes left, expected 0 0", exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_decode();
        int s0, cyc;
        drive_reg(16'hFF45, 8'h80);
        s0 = strobe_cnt;
        repeat (8) tick();
        tests_run++;
        if (strobe_cnt - s0 !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode_ignored: %0d strobes busy %b, expected 0 0", strobe_cnt - s0, busy);
        end
        reg_addr = DMA_REG;
        #1;
        tests_run++;
        if (reg_rdata !== 8'hC0) begin
            tests_failed++;
            $display("FAIL decode_page_kept: got %h expected C0", reg_rdata);
        end
        push_copy(8'h80, 160, 160);
        drive_reg(DMA_REG, 8'h80);
        tests_run++;
        if (reg_rdata !== 8'h80) begin
            tests_failed++;
            $display("FAIL decode_readback: got %h expected 80", reg_rdata);
        end
        reg_addr = 16'hFF45;
        #1;
        tests_run++;
        if (reg_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL decode_other_addr: got %h expected 00", reg_rdata);
        end
        wait_done(600, cyc);
        tick();
        tests_run++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL decode_drained: %0d reads %0d writes left, cycles %0d", exp_rd.size(), exp_wr.size(), cyc);
        end
    endtask

    task automatic test_restart();
        int d0, cyc;
        d0 = done_cnt;
        push_copy(8'hC0, 51, 51);
        drive_reg(DMA_REG, 8'hC0);
        repeat (152) tick();
        tests_run++;
        if (m_we !== 1'b1 || m_addr !== 16'hFE32) begin
            tests_failed++;
            $display("FAIL restart_inflight_write: we %b addr %h, expected 1 FE32", m_we, m_addr);
        end
        push_copy(8'hD0, 160, 160);
        drive_reg(DMA_REG, 8'hD0);
        tests_run++;
        if (m_re !== 1'b1 || m_addr !== 16'hD000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_first_read: re %b addr %h busy %b, expected 1 D000 1", m_re, m_addr, busy);
        end
        wait_done(600, cyc);
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL restart_complete: %0d done pulses, %0d reads %0d writes left, expected 1 0 0",
                     done_cnt - d0, exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0, cyc;
        d0 = done_cnt;
        push_copy(8'hC0, 160, 160);
        drive_reg(DMA_REG, 8'hC0);
        repeat (479) tick();
        tests_run++;
        if (m_we !== 1'b1 || m_addr !== 16'hFE9F) begin
            tests_failed++;
            $display("FAIL b2b_final_write: we %b addr %h, expected 1 FE9F", m_we, m_addr);
        end
        push_copy(8'h40, 160, 160);
        drive_reg(DMA_REG, 8'h40);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1 || m_re !== 1'b1 || m_addr !== 16'h4000) begin
            tests_failed++;
            $display("FAIL b2b_restart: done %b busy %b re %b addr %h, expected 0 1 1 4000",
                     done, busy, m_re, m_addr);
        end
        wait_done(600, cyc);
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_complete: %0d done pulses, %0d reads %0d writes left, expected 1 0 0",
                     done_cnt - d0, exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0, s0;
        d0 = done_cnt;
        push_copy(8'hC0, 21, 20);
        drive_reg(DMA_REG, 8'hC0);
        repeat (60) tick();
        tests_run++;
        if (m_re !== 1'b1 || m_addr !== 16'hC014) begin
            tests_failed++;
            $display("FAIL midrst_at_byte20: re %b addr %h, expected 1 C014", m_re, m_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reg_addr = DMA_REG;
        #1;
        tests_run++;
        if ({m_addr, m_wdata, m_re, m_we, busy, done} !== 28'h0 || reg_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_state: addr %h wdata %h re %b we %b busy %b done %b page %h, expected all 0",
                     m_addr, m_wdata, m_re, m_we, busy, done, reg_rdata);
        end
        s0 = strobe_cnt;
        repeat (20) tick();
        tests_run++;
        if (strobe_cnt - s0 !== 0 || done_cnt - d0 !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: %0d strobes %0d done busy %b, expected 0 0 0",
                     strobe_cnt - s0, done_cnt - d0, busy);
        end
        tests_run++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_drained: %0d reads %0d writes left, expected 0 0", exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic test_page_ff();
        int d0, cyc;
        d0 = done_cnt;
        push_copy(8'hFF, 160, 160);
        drive_reg(DMA_REG, 8'hFF);
        tests_run++;
        if (m_re !== 1'b1 || m_addr !== 16'hFF00) begin
            tests_failed++;
            $display("FAIL pageff_first_read: re %b addr %h, expected 1 FF00", m_re, m_addr);
        end
        wait_done(600, cyc);
        tick();
        tests_run++;
        if (cyc !== 480 || done_cnt - d0 !== 1 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
            tests_failed++;
            $display("FAIL pageff_complete: done after %0d, %0d pulses, %0d reads %0d writes left, expected 480 1 0 0",
                     cyc, done_cnt - d0, exp_rd.size(), exp_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_decode();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_page_ff();
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
